// File: rtl/axi_sram_pipe.sv
// axi_sram_pipe: on-chip SRAM back-end for the axi_slv request/response
// interface. It has a configurable in-order read/response latency, range and
// write-lock error reporting, an optional post-reset clear engine and a
// saturating error counter.
module axi_sram_pipe #(
  parameter int abits            = 12,
  parameter int log2_dbytes      = 3,
  parameter int rd_latency       = 1,
  parameter bit clear_on_reset   = 1'b0,
  parameter int sysbus_addr_bits = 48
) (
  input  logic                            i_clk,
  input  logic                            i_nrst,
  input  logic                            i_req_valid,
  input  logic [sysbus_addr_bits-1:0]     i_req_addr,
  input  logic [7:0]                      i_req_size,
  input  logic                            i_req_write,
  input  logic [(8<<log2_dbytes)-1:0]     i_req_wdata,
  input  logic [(1<<log2_dbytes)-1:0]     i_req_wstrb,
  input  logic                            i_req_last,
  input  logic                            i_wr_lock,
  output logic                            o_req_ready,
  output logic                            o_resp_valid,
  output logic [(8<<log2_dbytes)-1:0]     o_resp_rdata,
  output logic                            o_resp_err,
  output logic                            o_clear_busy,
  output logic [15:0]                     o_err_cnt
);

  localparam int DataBytes = 1 << log2_dbytes;
  localparam int DataBits  = 8 * DataBytes;
  localparam int IdxBits   = abits - log2_dbytes;
  localparam int Words     = 1 << IdxBits;
  localparam logic [IdxBits-1:0] LastIdx = IdxBits'(Words - 1);

  typedef enum logic {
    StateClear,
    StateRun
  } stateT;

  stateT                r_state;
  logic [IdxBits-1:0]   r_clearCnt;
  logic                 r_reqReady;
  logic                 r_clearBusy;
  logic [DataBits-1:0]  r_mem [Words];
  logic                 r_vld  [rd_latency];
  logic                 r_err  [rd_latency];
  logic [DataBits-1:0]  r_data [rd_latency];
  logic [15:0]          r_errCnt;

  logic                 w_accept;
  logic [IdxBits-1:0]   w_idx;
  logic                 w_rangeErr;
  logic                 w_lockErr;
  logic                 w_err;
  logic                 w_unused;

  // Request decode: word index from the in-window address bits, errors from
  // address bits above the array and from writes while the array is locked.
  assign w_accept   = i_req_valid & r_reqReady;
  assign w_idx      = i_req_addr[abits-1:log2_dbytes];
  assign w_rangeErr = |i_req_addr[sysbus_addr_bits-1:abits];
  assign w_lockErr  = i_req_write & i_wr_lock;
  assign w_err      = w_rangeErr | w_lockErr;

  // Size, burst-last and the byte offset carry no meaning for a whole-word
  // array governed by byte strobes.
  assign w_unused = ^{i_req_size, i_req_last, i_req_addr[log2_dbytes-1:0]};

  // Control FSM: sweep every word to zero after reset (if enabled), then
  // accept one request per cycle forever; ready and busy are registered.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= clear_on_reset ? StateClear : StateRun;
      r_clearCnt  <= '0;
      r_clearBusy <= clear_on_reset;
      r_reqReady  <= 1'b0;
    end else begin
      case (r_state)
        StateClear: begin
          r_clearCnt <= r_clearCnt + 1'b1;
          if (r_clearCnt == LastIdx) begin
            r_state     <= StateRun;
            r_clearBusy <= 1'b0;
            r_reqReady  <= 1'b1;
          end
        end
        StateRun: begin
          r_clearBusy <= 1'b0;
          r_reqReady  <= 1'b1;
        end
        default: r_state <= StateRun;
      endcase
    end
  end

  // Array write port: clear-engine zeroing, or a byte-strobed error-free write.
  always_ff @(posedge i_clk) begin
    if (r_state == StateClear) begin
      r_mem[r_clearCnt] <= '0;
    end else if (w_accept && i_req_write && !w_err) begin
      for (int k = 0; k < DataBytes; k++) begin
        if (i_req_wstrb[k]) begin
          r_mem[w_idx][8*k +: 8] <= i_req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 samples the array at the accept edge and the
  // remaining stages delay it; reset drops every in-flight response.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int i = 0; i < rd_latency; i++) begin
        r_vld[i]  <= 1'b0;
        r_err[i]  <= 1'b0;
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_accept;
      r_err[0]  <= w_accept & w_err;
      r_data[0] <= (w_accept && !i_req_write && !w_err) ? r_mem[w_idx] : '0;
      for (int i = 1; i < rd_latency; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_err[i]  <= r_err[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Saturating count of error responses as they leave the pipeline.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_errCnt <= '0;
    end else if (r_vld[rd_latency-1] && r_err[rd_latency-1] && (r_errCnt != 16'hFFFF)) begin
      r_errCnt <= r_errCnt + 16'd1;
    end
  end

  assign o_req_ready  = r_reqReady;
  assign o_clear_busy = r_clearBusy;
  assign o_resp_valid = r_vld[rd_latency-1];
  assign o_resp_err   = r_err[rd_latency-1];
  assign o_resp_rdata = r_data[rd_latency-1];
  assign o_err_cnt    = r_errCnt;

endmodule
